result_matrix_collector: RTL

//  Downstream sink of the sequential matrix multiplier. Captures every z_out/z_i/z_j

---
 rtl/result_matrix_collector.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/result_matrix_collector.sv
// result_matrix_collector
//   Sink for the sequential matrix multiplier. Every z_in/z_i/z_j beat taken on
//   the z_stb/z_ack handshake is written into an m x m array of 32-bit words.
//   Later beats overwrite earlier ones, so each cell ends up holding its final sum.
//   The block counts accepted beats and flags completion after m*m*m beats.
//   Any cell can be read through a registered random-read port.
//
// Optional feature: define RESULT_STREAM_EN to add a valid/ready stream port.
//   When enabled, the finished matrix is replayed once, in row-major order,
//   after matrix_valid rises.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   clear             synchronous clear of counter, flags, FSM and stream
//                     (array contents are kept)
//   z_in, z_i, z_j    result word and its row/column index
//   z_stb, z_ack      producer strobe (held until acked) / one-cycle acknowledge
//   rd_i, rd_j        read address
//   rd_data           registered read data, 1-cycle latency
//   beat_count        accepted beats since reset/clear, saturating at m*m*m
//   matrix_valid      high once beat_count reaches m*m*m
//   overrun           sticky: a beat was accepted while matrix_valid was high
//   st_* (RESULT_STREAM_EN only)
//                     st_data, st_i, st_j, st_valid, st_last out; st_ready in

module result_matrix_collector #(
  parameter int m     = 4,
  parameter int m_len = $clog2(m),
  parameter int CNT_W = $clog2(m*m*m+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [31:0]      z_in,
  input  logic [m_len-1:0] z_i,
  input  logic [m_len-1:0] z_j,
  input  logic             z_stb,
  output logic             z_ack,
  input  logic [m_len-1:0] rd_i,
  input  logic [m_len-1:0] rd_j,
  output logic [31:0]      rd_data,
  output logic [CNT_W-1:0] beat_count,
  output logic             matrix_valid,
  output logic             overrun
`ifdef RESULT_STREAM_EN
  ,
  output logic [31:0]      st_data,
  output logic [m_len-1:0] st_i,
  output logic [m_len-1:0] st_j,
  output logic             st_valid,
  output logic             st_last,
  input  logic             st_ready
`endif
);

  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(m*m*m);
  localparam logic [m_len-1:0] LAST_IDX = m_len'(m-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        stream_busy;
  logic        wr_in_range;
  logic        rd_in_range;
  logic [31:0] arr [m][m];

  // When m is not a power of two, the index fields can name cells that
  // do not exist. Such beats are still acked and counted, but not stored.
  assign wr_in_range = (int'(z_i) < m) && (int'(z_j) < m);
  assign rd_in_range = (int'(rd_i) < m) && (int'(rd_j) < m);

  // Handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // A beat is only taken from S_IDLE. The S_ACK / S_WAIT_LOW guard stops
  // a strobe that is still held high from being captured a second time.
  // clear wins over a same-cycle strobe; the strobe is taken on the next cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (z_stb && !stream_busy) begin
            accept     = 1'b1;
            state_next = S_ACK;
          end
        end
        S_ACK: begin
          state_next = S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!z_stb) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Acknowledge pulse, beat counter and completion/overrun flags.
  // The count stops advancing once matrix_valid is set. That is what makes
  // it saturate. Any further beat only raises overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_ack        <= 1'b0;
      beat_count   <= '0;
      matrix_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear) begin
      z_ack        <= 1'b0;
      beat_count   <= '0;
      matrix_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      z_ack <= accept;
      if (accept) begin
        if (matrix_valid) begin
          overrun <= 1'b1;
        end else begin
          beat_count <= beat_count + 1'b1;
          if (beat_count == BEAT_MAX - 1'b1) begin
            matrix_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Result storage. Only reset clears it; clear leaves the old results
  // readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < m; a++) begin
        for (int b = 0; b < m; b++) begin
          arr[a][b] <= '0;
        end
      end
    end else if (accept && wr_in_range) begin
      arr[z_i][z_j] <= z_in;
    end
  end

  // Registered read port. A read of a cell being written on the same edge
  // returns the value from before the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_in_range ? arr[rd_i][rd_j] : 32'h0;
    end
  end

`ifdef RESULT_STREAM_EN
  logic             stream_active;
  logic             stream_done;
  logic             stream_start;
  logic [m_len-1:0] nxt_i;
  logic [m_len-1:0] nxt_j;
  logic             nxt_last;

  // stream_done limits the replay to one per completion. Only clear or
  // reset re-arms it, and both of those also drop matrix_valid.
  assign stream_start = matrix_valid && !stream_done && !stream_active;

  // Block new beats from the cycle the replay is about to start until the
  // last word has been taken.
  assign stream_busy  = stream_active || stream_start;

  // Row-major successor of the cell currently presented.
  always_comb begin
    nxt_i = st_i;
    nxt_j = st_j + 1'b1;
    if (st_j == LAST_IDX) begin
      nxt_i = st_i + 1'b1;
      nxt_j = '0;
    end
    nxt_last = (nxt_i == LAST_IDX) && (nxt_j == LAST_IDX);
  end

  // Stream output registers. A word stays stable until it is taken
  // (st_valid && st_ready). The next word is then loaded straight from
  // the array. No beats are accepted during the replay, so the array
  // cannot change under it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_active <= 1'b0;
      stream_done   <= 1'b0;
      st_data       <= '0;
      st_i          <= '0;
      st_j          <= '0;
      st_valid      <= 1'b0;
      st_last       <= 1'b0;
    end else if (clear) begin
      stream_active <= 1'b0;
      stream_done   <= 1'b0;
      st_data       <= '0;
      st_i          <= '0;
      st_j          <= '0;
      st_valid      <= 1'b0;
      st_last       <= 1'b0;
    end else if (stream_start) begin
      stream_active <= 1'b1;
      stream_done   <= 1'b1;
      st_data       <= arr[0][0];
      st_i          <= '0;
      st_j          <= '0;
      st_valid      <= 1'b1;
      st_last       <= (m == 1);
    end else if (stream_active && st_valid && st_ready) begin
      if (st_last) begin
        stream_active <= 1'b0;
        st_valid      <= 1'b0;
        st_last       <= 1'b0;
      end else begin
        st_i    <= nxt_i;
        st_j    <= nxt_j;
        st_data <= arr[nxt_i][nxt_j];
        st_last <= nxt_last;
      end
    end
  end
`else
  assign stream_busy = 1'b0;
`endif

endmodule
